amp_vector_pipe: RTL and testbench

- Parametrised elastic pipeline for state-vector amplitude samples. It replaces the single-stage enable register bank.
- Carries a vector of sample_size signed complex words through DEPTH register stages with valid/ready flow control, flush, and an occupancy count.
- Sits between the amplitude update datapath (oracle/diffusion) and downstream consumers that may stall.

---
 rtl/amp_pkg.sv | 11 +
 rtl/amp_pipe_stage.sv | 36 +++
 rtl/amp_vector_pipe.sv | 95 +++++++++
 tb/tb_amp_vector_pipe.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/amp_pkg.sv
// Shared amplitude-vector types and default widths for the oracle/diffusion datapath.
package amp_pkg;

  localparam int unsigned COMPLEX_W   = 24;
  localparam int unsigned SAMPLE_SIZE = 4;
  localparam int unsigned AMP_VEC_W   = COMPLEX_W * SAMPLE_SIZE;

  typedef logic signed [COMPLEX_W-1:0] amp_word_t;
  typedef amp_word_t [SAMPLE_SIZE-1:0] amp_vec_t;

endpackage

// File: rtl/amp_pipe_stage.sv
// One elastic stage: valid bit plus vector register, loads whenever it is empty or downstream drains.
module amp_pipe_stage
  import amp_pkg::*;
#(
  parameter int unsigned VW = AMP_VEC_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          src_valid,
  input  logic [VW-1:0] src_data,
  input  logic          ready_next,
  output logic          valid,
  output logic [VW-1:0] data
);

  logic load;

  assign load = ~valid | ready_next;

  // Data only captures valid words so bubbles do not toggle the register bank.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= src_valid;
      if (src_valid) begin
        data <= src_data;
      end
    end
  end

endmodule

// File: rtl/amp_vector_pipe.sv
// DEPTH-stage valid/ready pipeline for amplitude vectors with flush and registered occupancy.
module amp_vector_pipe
  import amp_pkg::*;
#(
  parameter  int unsigned sample_size    = SAMPLE_SIZE,
  parameter  int unsigned complexnum_bit = COMPLEX_W,
  parameter  int unsigned DEPTH          = 2,
  localparam int unsigned CNT_W          = $clog2(DEPTH + 1)
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          flush,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic signed [sample_size-1:0][complexnum_bit-1:0] in,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic signed [sample_size-1:0][complexnum_bit-1:0] out,
  output logic [CNT_W-1:0]                              occupancy
);

  localparam int unsigned VW = sample_size * complexnum_bit;

  if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
    $error("amp_vector_pipe: DEPTH must be in 1..16");
  end

  logic [DEPTH-1:0] stage_valid;
  logic [VW-1:0]    stage_data [DEPTH];
  logic [DEPTH:0]   rdy;
  logic             in_fire;
  logic             out_fire;

  // Ready chain unrolled from the output side; depends only on valids and out_ready.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = out_ready;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      rdy[k] = rdy[k+1] | ~stage_valid[k];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic          src_valid;
    logic [VW-1:0] src_data;

    if (k == 0) begin : g_head
      assign src_valid = in_valid;
      assign src_data  = in;
    end else begin : g_body
      assign src_valid = stage_valid[k-1];
      assign src_data  = stage_data[k-1];
    end

    amp_pipe_stage #(.VW(VW)) u_stage (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .src_valid  (src_valid),
      .src_data   (src_data),
      .ready_next (rdy[k+1]),
      .valid      (stage_valid[k]),
      .data       (stage_data[k])
    );
  end

  assign in_ready  = rdy[0];
  assign out_valid = stage_valid[DEPTH-1];
  assign out       = stage_data[DEPTH-1];

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else if (in_fire && !out_fire) begin
      occupancy <= occupancy + CNT_W'(1);
    end else if (out_fire && !in_fire) begin
      occupancy <= occupancy - CNT_W'(1);
    end
  end

  // Counter must track the stage valids and stay inside 0..DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (occupancy == CNT_W'($countones(stage_valid)));
      assert (!(out_fire && !in_fire && occupancy == '0));
      assert (!(in_fire && !out_fire && occupancy == CNT_W'(DEPTH)));
    end
  end

endmodule

// File: tb/tb_amp_vector_pipe.sv
// Directed scoreboard bench for amp_vector_pipe at DEPTH 2, 4 and 1.
module tb_amp_vector_pipe;

  typedef logic [3:0][23:0] vec_t;

  logic clk = 1'b0;
  logic rst;

  logic f2, iv2, ir2, ov2, or2;
  vec_t in2, out2;
  logic [1:0] occ2;

  logic f4, iv4, ir4, ov4, or4;
  vec_t in4, out4;
  logic [2:0] occ4;

  logic f1, iv1, ir1, ov1, or1;
  vec_t in1, out1;
  logic [0:0] occ1;

  vec_t q2[$];
  vec_t q4[$];
  vec_t q1[$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  amp_vector_pipe #(.DEPTH(2)) d2 (
    .clk(clk), .rst(rst), .flush(f2), .in_valid(iv2), .in_ready(ir2), .in(in2),
    .out_valid(ov2), .out_ready(or2), .out(out2), .occupancy(occ2));

  amp_vector_pipe #(.DEPTH(4)) d4 (
    .clk(clk), .rst(rst), .flush(f4), .in_valid(iv4), .in_ready(ir4), .in(in4),
    .out_valid(ov4), .out_ready(or4), .out(out4), .occupancy(occ4));

  amp_vector_pipe #(.DEPTH(1)) d1 (
    .clk(clk), .rst(rst), .flush(f1), .in_valid(iv1), .in_ready(ir1), .in(in1),
    .out_valid(ov1), .out_ready(or1), .out(out1), .occupancy(occ1));

  function automatic vec_t mk(int a, int b, int c, int d);
    vec_t v;
    v[0] = 24'(a);
    v[1] = 24'(b);
    v[2] = 24'(c);
    v[3] = 24'(d);
    return v;
  endfunction

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample handshakes at the falling edge, then advance past the next rising edge.
  task automatic tick();
    vec_t e;
    @(negedge clk);
    if (!rst) begin
      q2.delete(); q4.delete(); q1.delete();
    end else begin
      if (f2) q2.delete();
      else begin
        if (ov2 && or2) begin
          chk("d2_sb_avail", 128'(q2.size() != 0), 128'(1'b1));
          if (q2.size() != 0) begin e = q2.pop_front(); chk("d2_out", 128'(out2), 128'(e)); end
        end
        if (iv2 && ir2) q2.push_back(in2);
      end
      if (f4) q4.delete();
      else begin
        if (ov4 && or4) begin
          chk("d4_sb_avail", 128'(q4.size() != 0), 128'(1'b1));
          if (q4.size() != 0) begin e = q4.pop_front(); chk("d4_out", 128'(out4), 128'(e)); end
        end
        if (iv4 && ir4) q4.push_back(in4);
      end
      if (f1) q1.delete();
      else begin
        if (ov1 && or1) begin
          chk("d1_sb_avail", 128'(q1.size() != 0), 128'(1'b1));
          if (q1.size() != 0) begin e = q1.pop_front(); chk("d1_out", 128'(out1), 128'(e)); end
        end
        if (iv1 && ir1) q1.push_back(in1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v [4];
    vec_t x, x2;
    v[0] = mk(1, -1, 2, -2);
    v[1] = mk(3, -3, 4, -4);
    v[2] = mk(5, -5, 6, -6);
    v[3] = mk(7, -7, 8, -8);
    x  = mk(-8388608, 8388607, -1, 0);
    x2 = mk(8388607, -8388608, 0, -1);

    rst = 1'b0;
    f2 = 1'b0; iv2 = 1'b1; in2 = mk(5, -3, 7, -8); or2 = 1'b1;
    f4 = 1'b0; iv4 = 1'b0; in4 = '0; or4 = 1'b1;
    f1 = 1'b0; iv1 = 1'b0; in1 = '0; or1 = 1'b1;

    // reset with a vector presented
    repeat (2) tick();
    chk("rst_out", 128'(out2), 128'(0));
    chk("rst_ov", 128'(ov2), 128'(0));
    chk("rst_occ", 128'(occ2), 128'(0));
    chk("rst_occ4", 128'(occ4), 128'(0));
    rst = 1'b1; iv2 = 1'b0;
    #1;
    chk("rst_in_ready", 128'(ir2), 128'(1));

    // latency and throughput
    iv2 = 1'b1; in2 = v[0]; tick();
    chk("lat_ov_t1", 128'(ov2), 128'(0));
    chk("lat_occ_t1", 128'(occ2), 128'(1));
    in2 = v[1]; tick();
    chk("lat_ov_t2", 128'(ov2), 128'(1));
    chk("lat_out_t2", 128'(out2), 128'(v[0]));
    chk("lat_occ_t2", 128'(occ2), 128'(2));
    in2 = v[2]; tick();
    chk("tput_out3", 128'(out2), 128'(v[1]));
    chk("tput_occ3", 128'(occ2), 128'(2));
    in2 = v[3]; tick();
    chk("tput_out4", 128'(out2), 128'(v[2]));
    chk("tput_occ4", 128'(occ2), 128'(2));
    iv2 = 1'b0; repeat (3) tick();
    chk("tput_drain_occ", 128'(occ2), 128'(0));
    chk("tput_drain_sb", 128'(q2.size()), 128'(0));

    // backpressure
    or2 = 1'b0; iv2 = 1'b1; in2 = v[0]; tick();
    in2 = v[1]; tick();
    in2 = v[2];
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 128'(ir2), 128'(0));
      chk("bp_out", 128'(out2), 128'(v[0]));
      chk("bp_occ", 128'(occ2), 128'(2));
      tick();
    end
    iv2 = 1'b0; or2 = 1'b1; repeat (3) tick();
    chk("bp_drain_occ", 128'(occ2), 128'(0));
    chk("bp_drain_sb", 128'(q2.size()), 128'(0));

    // bubble collapse under a stall
    or2 = 1'b0; iv2 = 1'b1; in2 = v[0]; tick();
    iv2 = 1'b0; tick();
    iv2 = 1'b1; in2 = v[1]; tick();
    iv2 = 1'b0;
    #1;
    chk("bub_occ", 128'(occ2), 128'(2));
    chk("bub_out", 128'(out2), 128'(v[0]));
    chk("bub_in_ready", 128'(ir2), 128'(0));
    or2 = 1'b1; repeat (3) tick();
    chk("bub_drain_sb", 128'(q2.size()), 128'(0));

    // flush on a full pipe with a vector offered
    or2 = 1'b0; iv2 = 1'b1; in2 = v[0]; tick();
    in2 = v[1]; tick();
    f2 = 1'b1; in2 = v[2]; tick();
    f2 = 1'b0; iv2 = 1'b0;
    chk("fl_ov", 128'(ov2), 128'(0));
    chk("fl_occ", 128'(occ2), 128'(0));
    or2 = 1'b1; repeat (4) tick();
    chk("fl_quiet_ov", 128'(ov2), 128'(0));

    // flush while in_ready is high discards the offered vector
    or2 = 1'b0; iv2 = 1'b1; in2 = v[0]; tick();
    iv2 = 1'b0; tick();
    chk("fl2_in_ready", 128'(ir2), 128'(1));
    f2 = 1'b1; iv2 = 1'b1; in2 = v[3]; tick();
    f2 = 1'b0; iv2 = 1'b0;
    chk("fl2_ov", 128'(ov2), 128'(0));
    chk("fl2_occ", 128'(occ2), 128'(0));
    or2 = 1'b1; repeat (4) tick();
    chk("fl2_quiet_ov", 128'(ov2), 128'(0));
    iv2 = 1'b1; in2 = v[1]; tick();
    iv2 = 1'b0; repeat (3) tick();
    chk("fl2_resume_sb", 128'(q2.size()), 128'(0));

    // reset mid-operation
    iv2 = 1'b1; in2 = v[0]; tick();
    in2 = v[1]; tick();
    rst = 1'b0; iv2 = 1'b0; tick();
    rst = 1'b1;
    chk("mrst_ov", 128'(ov2), 128'(0));
    chk("mrst_occ", 128'(occ2), 128'(0));
    repeat (3) tick();
    chk("mrst_quiet_ov", 128'(ov2), 128'(0));

    // DEPTH=4 extremes
    iv4 = 1'b1; in4 = x; tick();
    iv4 = 1'b0; repeat (2) tick();
    chk("d4_ov_t3", 128'(ov4), 128'(0));
    tick();
    chk("d4_ov_t4", 128'(ov4), 128'(1));
    chk("d4_out_t4", 128'(out4), 128'(x));
    iv4 = 1'b1;
    in4 = x2; tick();
    in4 = x;  tick();
    in4 = x2; tick();
    in4 = x;  tick();
    chk("d4_stream_occ", 128'(occ4), 128'(4));
    iv4 = 1'b0; repeat (6) tick();
    chk("d4_drain_occ", 128'(occ4), 128'(0));
    chk("d4_drain_sb", 128'(q4.size()), 128'(0));

    // DEPTH=1 handshake
    iv1 = 1'b1; in1 = x; tick();
    chk("d1_ov", 128'(ov1), 128'(1));
    chk("d1_out_x", 128'(out1), 128'(x));
    chk("d1_ir_ovr", 128'(ir1), 128'(1));
    or1 = 1'b0; in1 = x2;
    #1;
    chk("d1_ir_stall", 128'(ir1), 128'(0));
    tick();
    chk("d1_hold", 128'(out1), 128'(x));
    chk("d1_occ_hold", 128'(occ1), 128'(1));
    or1 = 1'b1;
    #1;
    chk("d1_ir_release", 128'(ir1), 128'(1));
    tick();
    chk("d1_out_x2", 128'(out1), 128'(x2));
    iv1 = 1'b0; tick();
    chk("d1_empty_ov", 128'(ov1), 128'(0));
    chk("d1_empty_occ", 128'(occ1), 128'(0));
    chk("d1_empty_ir", 128'(ir1), 128'(1));
    chk("d1_sb", 128'(q1.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
